control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit sitting directly upstream of the datapath. Steps through the
//  T0..T6 timing states, runs the instruction fetch (T0-T2), decodes IR[31:27] and drives
//  the datapath strobes (PCout, MARin, Read, MDRin, IRin, Yin, Zin, Zlowout, ZHighout, HIin,
//  LOin, Gra/Gb/Gc + Rin/Rout) for register-register ALU instructions. Replaces hand-sequenced strobes.
// PARAMETERS
//  OPW      5   opcode width (IR[31:27])
//  ALUW     4   width of alu_op bus to datapath ALU
// PORTS
//  clock     in   1   system clock, all state updates on rising edge
//  clear     in   1   synchronous active-high reset
//  run       in   1   start request; sampled only in IDLE
//  ir        in   32  instruction register contents from datapath
//  PCout,IncPC,MARin,Read,MDRin,MDRout,IRin,Yin,Zin,Zlowout,ZHighout,HIin,LOin  out 1 each
//  Gra,Grb,Grc out 1 each  register-field selects to select/encode logic; Rin,Rout out 1 each
//  alu_op    out  4   ALU function, valid only while Zin=1 in execute states, else 0
//  running   out  1   high in every state except IDLE and HALT
//  illegal   out  1   one-cycle pulse in T3 on undefined opcode
// BEHAVIOUR
//  - State register: IDLE,T0,T1,T2,T3,T4,T5,T6,HALT. All outputs are pure decode of state and
//    ir[31:27]; no output is registered separately.
//  - Reset: clear=1 at a rising edge -> state IDLE; every output 0 from that edge on. clear
//    overrides run and any in-flight instruction (no partial completion; datapath is not rolled back).
//  - IDLE: run=1 -> T0, else stay. HALT: stay until clear.
//  - T0: PCout,IncPC,Zin,MARin. T1: Zlowout,PCin,Read,MDRin. T2: MDRout,IRin. All -> next T.
//  - Opcodes (ir[31:27]): 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 sra,
//    00110 shl, 00111 ror, 01000 rol, 01001 mul, 01010 div, 01011 neg, 01100 not,
//    11010 nop, 11011 halt; all others illegal. alu_op = ir[30:27] during execute Zin.
//  - Two-operand ALU (add..rol): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op; T5 Zlowout,Gra,Rin; ->T0.
//    Total 6 cycles per instruction.
//  - mul/div: T3,T4 as above; T5 Zlowout,LOin; T6 ZHighout,HIin; ->T0. 7 cycles.
//  - neg/not: T3 Grb,Rout,Zin,alu_op; T4 Zlowout,Gra,Rin; ->T0. 5 cycles.
//  - nop: T3 no strobes; ->T0 (4 cycles). halt: T3 no strobes; ->HALT.
//  - illegal: T3 illegal=1, no other strobes; ->T0 (treated as nop).
//  - Exactly one of Gra/Grb/Grc high whenever Rin or Rout is high; Rin and Rout never both high.
//  - Unused states for an opcode (e.g. T6 for add) never entered; any unreachable encoding -> IDLE.
//  - run ignored outside IDLE; after an instruction, sequencing continues at T0 without re-sampling run.
// TESTING
//  1 clear=1 one edge, run=1 -> IDLE then T0; T0 strobes PCout,IncPC,Zin,MARin; all outputs 0 while IDLE.
//  2 ir=32'h0088_0000 (add) -> T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=0; T5 Zlowout,Gra,Rin; T0 at cycle 7.
//  3 ir opcode 01001 (mul) -> T5 Zlowout,LOin; T6 ZHighout,HIin,alu_op=0 at T6; back to T0; 7 cycles.
//  4 ir opcode 01011 (neg) -> T3 Grb,Rout,Zin,alu_op=4'b1011, Yin=0; T4 Gra,Rin; next T0.
//  5 ir opcode 11111 -> illegal=1 for exactly the T3 cycle, no Rin/Rout, next T0; opcode 11011 -> HALT,
//    running=0, held across 10 cycles with run=1 until clear.
//  6 clear=1 during T4 of an add -> state IDLE next edge, Rin never asserted, running=0.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the datapath. A single state register walks the
// T0..T6 timing states: T0-T2 perform the instruction fetch, T3 onward execute
// the instruction selected by the opcode field ir[31:27]. Every strobe is a
// pure combinational decode of the current state and the opcode, so strobes
// are valid for the whole cycle that the state is held.
//
// Ports
//   clock      in   system clock, all state updates on the rising edge
//   clear      in   synchronous active-high reset, overrides everything
//   run        in   start request, only looked at while IDLE
//   ir         in   instruction register contents (opcode in [31:27])
//   PCout .. LOin, PCin   out  datapath bus/register strobes
//   Gra/Grb/Grc out  register-field selects for the select/encode logic
//   Rin/Rout    out  general register load / drive strobes
//   alu_op      out  ALU function, only nonzero while Zin is high in execute
//   running     out  high in every state except IDLE and HALT
//   illegal     out  one-cycle pulse in T3 for an undefined opcode
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [31:0]     ir,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            ZHighout,
    output logic            HIin,
    output logic            LOin,
    output logic            PCin,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [ALUW-1:0] alu_op,
    output logic            running,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t          r_state;
    state_t          w_state_next;
    logic [OPW-1:0]  w_opcode;
    logic            w_is_alu2;
    logic            w_is_muldiv;
    logic            w_is_unary;
    logic            w_is_nop;
    logic            w_is_halt;
    logic            w_is_illegal;
    logic            w_unused;

    assign w_opcode = ir[31 -: OPW];

    // Operand and immediate fields are consumed by the select/encode logic,
    // not by the sequencer.
    assign w_unused = ^ir[31-OPW:0];

    // Instruction classes; anything not covered is treated as illegal.
    assign w_is_alu2    = (w_opcode <= OP_ROL);
    assign w_is_muldiv  = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
    assign w_is_unary   = (w_opcode == OP_NEG) || (w_opcode == OP_NOT);
    assign w_is_nop     = (w_opcode == OP_NOP);
    assign w_is_halt    = (w_opcode == OP_HALT);
    assign w_is_illegal = !(w_is_alu2 || w_is_muldiv || w_is_unary ||
                            w_is_nop || w_is_halt);

    // -------------------------------------------------------------------------
    // Next-state logic. States an opcode does not use fall straight back to
    // T0, so a changed ir in the middle of execute can never strand the FSM.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: w_state_next = run ? S_T0 : S_IDLE;
            S_T0:   w_state_next = S_T1;
            S_T1:   w_state_next = S_T2;
            S_T2:   w_state_next = S_T3;
            S_T3: begin
                if (w_is_halt)
                    w_state_next = S_HALT;
                else if (w_is_alu2 || w_is_muldiv || w_is_unary)
                    w_state_next = S_T4;
                else
                    w_state_next = S_T0;
            end
            S_T4:   w_state_next = (w_is_alu2 || w_is_muldiv) ? S_T5 : S_T0;
            S_T5:   w_state_next = w_is_muldiv ? S_T6 : S_T0;
            S_T6:   w_state_next = S_T0;
            S_HALT: w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Strobe decode. alu_op is only presented alongside Zin in execute states;
    // the T0 Zin (PC increment) leaves it at zero.
    // -------------------------------------------------------------------------
    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        PCin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = '0;
        running  = 1'b0;
        illegal  = 1'b0;
        case (r_state)
            S_T0: begin
                running = 1'b1;
                PCout   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                MARin   = 1'b1;
            end
            S_T1: begin
                running = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                running = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
            end
            S_T3: begin
                running = 1'b1;
                if (w_is_alu2 || w_is_muldiv) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (w_is_unary) begin
                    Grb    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = w_opcode[ALUW-1:0];
                end else if (w_is_illegal) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                running = 1'b1;
                if (w_is_alu2 || w_is_muldiv) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = w_opcode[ALUW-1:0];
                end else if (w_is_unary) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            S_T5: begin
                running = 1'b1;
                if (w_is_alu2) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (w_is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                running = 1'b1;
                if (w_is_muldiv) begin
                    ZHighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: begin
                // IDLE, HALT and unreachable encodings drive nothing.
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. The stimulus block pushes the output
// vector expected for each upcoming cycle into a queue; a checker on the
// falling clock edge pops it and compares against the live outputs, and also
// checks the register-select rules (Rin/Rout exclusive, one G select).
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic        Zlowout, ZHighout, HIin, LOin, PCin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [3:0]  alu_op;
    logic        running;
    logic        illegal;

    control_sequencer #(.OPW(5), .ALUW(4)) dut (
        .clock    (clock),
        .clear    (clear),
        .run      (run),
        .ir       (ir),
        .PCout    (PCout),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .ZHighout (ZHighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .PCin     (PCin),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .alu_op   (alu_op),
        .running  (running),
        .illegal  (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector layout: 19 strobes, alu_op[5:2], running[1], illegal[0].
    localparam logic [24:0] B_PCOUT  = 25'h1 << 24;
    localparam logic [24:0] B_INCPC  = 25'h1 << 23;
    localparam logic [24:0] B_MARIN  = 25'h1 << 22;
    localparam logic [24:0] B_READ   = 25'h1 << 21;
    localparam logic [24:0] B_MDRIN  = 25'h1 << 20;
    localparam logic [24:0] B_MDROUT = 25'h1 << 19;
    localparam logic [24:0] B_IRIN   = 25'h1 << 18;
    localparam logic [24:0] B_YIN    = 25'h1 << 17;
    localparam logic [24:0] B_ZIN    = 25'h1 << 16;
    localparam logic [24:0] B_ZLOW   = 25'h1 << 15;
    localparam logic [24:0] B_ZHIGH  = 25'h1 << 14;
    localparam logic [24:0] B_HIIN   = 25'h1 << 13;
    localparam logic [24:0] B_LOIN   = 25'h1 << 12;
    localparam logic [24:0] B_PCIN   = 25'h1 << 11;
    localparam logic [24:0] B_GRA    = 25'h1 << 10;
    localparam logic [24:0] B_GRB    = 25'h1 << 9;
    localparam logic [24:0] B_GRC    = 25'h1 << 8;
    localparam logic [24:0] B_RIN    = 25'h1 << 7;
    localparam logic [24:0] B_ROUT   = 25'h1 << 6;
    localparam logic [24:0] B_RUN    = 25'h1 << 1;
    localparam logic [24:0] B_ILL    = 25'h1;

    localparam logic [24:0] V_IDLE = 25'h0;
    localparam logic [24:0] V_T0   = B_PCOUT | B_INCPC | B_ZIN | B_MARIN | B_RUN;
    localparam logic [24:0] V_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [24:0] V_T2   = B_MDROUT | B_IRIN | B_RUN;
    localparam logic [24:0] V_OP_T3  = B_GRB | B_ROUT | B_YIN | B_RUN;
    localparam logic [24:0] V_OP_T4  = B_GRC | B_ROUT | B_ZIN | B_RUN;
    localparam logic [24:0] V_WB     = B_ZLOW | B_GRA | B_RIN | B_RUN;
    localparam logic [24:0] V_LO     = B_ZLOW | B_LOIN | B_RUN;
    localparam logic [24:0] V_HI     = B_ZHIGH | B_HIIN | B_RUN;
    localparam logic [24:0] V_UN_T3  = B_GRB | B_ROUT | B_ZIN | B_RUN;
    localparam logic [24:0] V_EMPTY  = B_RUN;
    localparam logic [24:0] V_ILL    = B_RUN | B_ILL;

    function automatic logic [24:0] alu(input logic [3:0] op);
        return {19'b0, op, 2'b0};
    endfunction

    logic [24:0] w_obs;
    logic        w_reg_ok;

    assign w_obs = {PCout, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
                    Zlowout, ZHighout, HIin, LOin, PCin, Gra, Grb, Grc, Rin, Rout,
                    alu_op, running, illegal};
    assign w_reg_ok = !(Rin && Rout) &&
                      (!(Rin || Rout) || $onehot({Gra, Grb, Grc}));

    logic [24:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Checker: one expected vector per falling edge while the queue is non-empty.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [24:0] exp_v;
            string       tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            n_checks++;
            assert (w_obs === exp_v) else begin
                n_errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, w_obs, exp_v);
            end
            n_checks++;
            assert (w_reg_ok === 1'b1) else begin
                n_errors++;
                $error("FAIL %s_regsel: observed Gra/Grb/Grc/Rin/Rout=%b expected legal select",
                       tag, {Gra, Grb, Grc, Rin, Rout});
            end
            $display("cycle %-14s obs=%h exp=%h", tag, w_obs, exp_v);
        end
    end

    // Expect vector v at the next falling edge; inputs are changed only just
    // after a falling edge, well away from both clock edges.
    task automatic cyc(input logic [24:0] v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        @(negedge clock);
        #1;
    endtask

    task automatic fetch(input string name);
        cyc(V_T1, {name, "_t1"});
        cyc(V_T2, {name, "_t2"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1;
        run   = 1'b1;
        ir    = 32'h0;

        // Reset overrides run; then IDLE holds with run low, starts with run high.
        cyc(V_IDLE, "reset_idle");
        clear = 1'b0;
        run   = 1'b0;
        cyc(V_IDLE, "idle_hold");
        run = 1'b1;
        cyc(V_T0, "start_t0");
        run = 1'b0;

        // add: 6 cycles, back to T0 without re-sampling run.
        ir = 32'h0088_0000;
        fetch("add");
        cyc(V_OP_T3, "add_t3");
        cyc(V_OP_T4 | alu(4'd0), "add_t4");
        cyc(V_WB, "add_t5");
        cyc(V_T0, "add_next_t0");

        // sub: alu_op carries the opcode low bits.
        ir = {5'b00001, 27'h0123456};
        fetch("sub");
        cyc(V_OP_T3, "sub_t3");
        cyc(V_OP_T4 | alu(4'd1), "sub_t4");
        cyc(V_WB, "sub_t5");
        cyc(V_T0, "sub_next_t0");

        // rol: last two-operand opcode.
        ir = {5'b01000, 27'h0};
        fetch("rol");
        cyc(V_OP_T3, "rol_t3");
        cyc(V_OP_T4 | alu(4'd8), "rol_t4");
        cyc(V_WB, "rol_t5");
        cyc(V_T0, "rol_next_t0");

        // mul: 7 cycles with LO/HI writeback.
        ir = {5'b01001, 27'h7ffffff};
        fetch("mul");
        cyc(V_OP_T3, "mul_t3");
        cyc(V_OP_T4 | alu(4'd9), "mul_t4");
        cyc(V_LO, "mul_t5");
        cyc(V_HI, "mul_t6");
        cyc(V_T0, "mul_next_t0");

        // div.
        ir = {5'b01010, 27'h0};
        fetch("div");
        cyc(V_OP_T3, "div_t3");
        cyc(V_OP_T4 | alu(4'd10), "div_t4");
        cyc(V_LO, "div_t5");
        cyc(V_HI, "div_t6");
        cyc(V_T0, "div_next_t0");

        // neg / not: 5 cycles, no Yin.
        ir = {5'b01011, 27'h0};
        fetch("neg");
        cyc(V_UN_T3 | alu(4'b1011), "neg_t3");
        cyc(V_WB, "neg_t4");
        cyc(V_T0, "neg_next_t0");
        ir = {5'b01100, 27'h0};
        fetch("not");
        cyc(V_UN_T3 | alu(4'b1100), "not_t3");
        cyc(V_WB, "not_t4");
        cyc(V_T0, "not_next_t0");

        // nop: 4 cycles.
        ir = {5'b11010, 27'h0};
        fetch("nop");
        cyc(V_EMPTY, "nop_t3");
        cyc(V_T0, "nop_next_t0");

        // illegal opcodes: all-ones and the first code past not.
        ir = {5'b11111, 27'h0};
        fetch("ill1f");
        cyc(V_ILL, "ill1f_t3");
        cyc(V_T0, "ill1f_next_t0");
        ir = {5'b01101, 27'h0};
        fetch("ill0d");
        cyc(V_ILL, "ill0d_t3");
        cyc(V_T0, "ill0d_next_t0");

        // clear during T4 of an add: IDLE next edge, no writeback.
        ir = 32'h0088_0000;
        fetch("clr");
        cyc(V_OP_T3, "clr_t3");
        cyc(V_OP_T4 | alu(4'd0), "clr_t4");
        clear = 1'b1;
        cyc(V_IDLE, "clr_idle");
        clear = 1'b0;
        cyc(V_IDLE, "clr_idle_hold");

        // halt: stays halted with run high until clear.
        run = 1'b1;
        cyc(V_T0, "restart_t0");
        run = 1'b0;
        ir = {5'b11011, 27'h0};
        fetch("halt");
        cyc(V_EMPTY, "halt_t3");
        run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(V_IDLE, $sformatf("halt_hold%0d", i));
        end
        clear = 1'b1;
        cyc(V_IDLE, "halt_clear");
        clear = 1'b0;
        cyc(V_T0, "halt_restart_t0");

        n_checks++;
        assert (exp_q.size() === 0) else begin
            n_errors++;
            $error("FAIL drain: observed %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
